// File: rtl/fir_pkg.sv
// Shared constants, types and index helper for the 64-tap sequential FIR engine.
package fir_pkg;

  localparam int TAPS = 64;
  localparam int DW   = 16;
  localparam int CW   = 16;
  localparam int AW   = 6;
  localparam int ACCW = DW + CW + AW;

  localparam logic [ACCW-1:0] RND = ACCW'(1 << 14);

  typedef logic signed [DW-1:0]   sample_t;
  typedef logic signed [CW-1:0]   coef_t;
  typedef logic signed [ACCW-1:0] acc_t;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    MAC,
    OUT,
    HOLD
  } state_t;

  // Delay-line slot holding the sample k steps older than the one at wp.
  function automatic logic [AW-1:0] tap_index(input logic [AW-1:0] wp, input logic [AW-1:0] k);
    return wp - k;
  endfunction

endpackage

// File: rtl/fir_mac_core_if.sv
// FIFO read side, coefficient write port and valid/ready result port of fir_mac_core.
interface fir_mac_core_if;
  import fir_pkg::*;

  logic          empty;
  logic [DW-1:0] out_read_data;
  logic          in_read_ctrl;

  logic          coef_we;
  logic [AW-1:0] coef_addr;
  logic [CW-1:0] coef_wdata;

  logic          busy;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          dout_ready;

  modport slave (
    input  empty, out_read_data, coef_we, coef_addr, coef_wdata, dout_ready,
    output in_read_ctrl, busy, dout, dout_valid
  );

  modport master (
    output empty, out_read_data, coef_we, coef_addr, coef_wdata, dout_ready,
    input  in_read_ctrl, busy, dout, dout_valid
  );

endinterface

// File: rtl/fir_mac.sv
// Signed MAC with clear plus Q15 round-half-up output stage; one tap per enabled cycle.
// FIR_SAT_EN defined: clamp to the 16-bit range; undefined: wrap to the low 16 bits.
module fir_mac
  import fir_pkg::*;
(
  input  logic    clk_r,
  input  logic    rstn,
  input  logic    clr,
  input  logic    en,
  input  coef_t   coef,
  input  sample_t sample,
  output sample_t result
);

  logic signed [DW+CW-1:0] prod;
  acc_t                    prod_ext;
  acc_t                    acc;
  acc_t                    rnd_sum;

  assign prod     = coef * sample;
  assign prod_ext = {{(ACCW-DW-CW){prod[DW+CW-1]}}, prod};

  always_ff @(posedge clk_r) begin
    if (!rstn) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + prod_ext;
    end
  end

  assign rnd_sum = acc + $signed(RND);

`ifdef FIR_SAT_EN
  acc_t                 q;
  logic [ACCW-DW:0]     q_hi;
  logic                 ovf;

  assign q    = rnd_sum >>> 15;
  assign q_hi = q[ACCW-1:DW-1];
  // In range only when every bit above the 16-bit sign position matches it.
  assign ovf  = !((&q_hi) || !(|q_hi));

  always_comb begin
    result = q[DW-1:0];
    if (ovf) begin
      result = q[ACCW-1] ? sample_t'(16'h8000) : sample_t'(16'h7FFF);
    end
  end
`else
  assign result = DW'(rnd_sum >>> 15);
`endif

endmodule

// File: rtl/fir_mac_core.sv
// Sequential 64-tap FIR: pops one FIFO word, runs 64 MAC cycles, holds the result until dout_ready.
// Read strobe to dout_valid is 67 cycles; no FIFO read is issued while a result waits in HOLD.
module fir_mac_core
  import fir_pkg::*;
(
  input  logic           clk_r,
  input  logic           rstn,
  fir_mac_core_if.slave  bus
);

  state_t        state;
  state_t        state_nxt;
  logic [AW-1:0] wp;
  logic [AW-1:0] k;
  logic [DW-1:0] line [TAPS];
  logic [CW-1:0] coef [TAPS];

  logic          rd;
  logic          mac_clr;
  logic          mac_en;
  logic          last_tap;
  sample_t       mac_result;
  logic [DW-1:0] dout_r;
  logic          dout_vld_r;

  assign last_tap = (k == AW'(TAPS - 1));

  always_comb begin
    state_nxt = state;
    rd        = 1'b0;
    mac_clr   = 1'b0;
    mac_en    = 1'b0;
    case (state)
      IDLE: begin
        if (!bus.empty) begin
          rd        = 1'b1;
          state_nxt = FETCH;
        end
      end
      FETCH: begin
        mac_clr   = 1'b1;
        state_nxt = MAC;
      end
      MAC: begin
        mac_en = 1'b1;
        if (last_tap) begin
          state_nxt = OUT;
        end
      end
      OUT: begin
        state_nxt = HOLD;
      end
      HOLD: begin
        if (bus.dout_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Gated by rstn so a FIFO word is never popped while the engine is held in reset.
  assign bus.in_read_ctrl = rd & rstn;
  assign bus.busy         = (state != IDLE);
  assign bus.dout         = dout_r;
  assign bus.dout_valid   = dout_vld_r;

  always_ff @(posedge clk_r) begin
    if (!rstn) begin
      state      <= IDLE;
      wp         <= '0;
      k          <= '0;
      dout_r     <= '0;
      dout_vld_r <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        FETCH: begin
          k <= '0;
        end
        MAC: begin
          k <= k + 1'b1;
        end
        OUT: begin
          dout_r     <= mac_result;
          dout_vld_r <= 1'b1;
          wp         <= wp + 1'b1;
        end
        HOLD: begin
          if (bus.dout_ready) begin
            dout_vld_r <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk_r) begin
    if (!rstn) begin
      for (int i = 0; i < TAPS; i++) begin
        line[i] <= '0;
      end
    end else if (state == FETCH) begin
      line[wp] <= bus.out_read_data;
    end
  end

  // Writes outside IDLE are dropped so a running sample always sees one coefficient set.
  always_ff @(posedge clk_r) begin
    if (!rstn) begin
      for (int i = 0; i < TAPS; i++) begin
        coef[i] <= '0;
      end
    end else if (state == IDLE && bus.coef_we) begin
      coef[bus.coef_addr] <= bus.coef_wdata;
    end
  end

  fir_mac u_mac (
    .clk_r  (clk_r),
    .rstn   (rstn),
    .clr    (mac_clr),
    .en     (mac_en),
    .coef   (coef[k]),
    .sample (line[tap_index(wp, k)]),
    .result (mac_result)
  );

endmodule
